// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner. Drives one active-low column at a time and samples the
// synchronized rows into a 16-bit scan image. After each full scan the image
// is classified as no key, one key or several keys. A result that repeats for
// STABLE_SCANS scans is accepted, and a newly accepted key gives one key_valid pulse.
module keypad_scanner #(
    parameter int CLK_FREQ     = 125_000_000,
    parameter int COL_DWELL_US = 250,
    parameter int STABLE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] col_n,
    input  logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi_key
);

    localparam int DWELL_CYC = (CLK_FREQ / 1_000_000) * COL_DWELL_US;
    localparam int DW        = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam int MW        = $clog2(STABLE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC - 1);
    localparam logic [MW-1:0] MATCH_MAX  = MW'(STABLE_SCANS);

    typedef enum logic       {S_DRIVE, S_EVAL} state_t;
    typedef enum logic [1:0] {C_NONE, C_SINGLE, C_MULTI} cls_t;

    state_t        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [3:0]    col_n_q, col_n_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [3:0]    row_s1_q, row_s1_d, row_s2_q, row_s2_d;
    logic [15:0]   acc_q, acc_d;
    logic          prev_vld_q, prev_vld_d;
    cls_t          prev_cls_q, prev_cls_d;
    logic [3:0]    prev_code_q, prev_code_d;
    logic [MW-1:0] match_q, match_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;
    logic          multi_key_q, multi_key_d;

    cls_t       cls;
    logic [3:0] code;
    logic [4:0] zcnt;
    logic [3:0] zidx;
    logic       same;

    // Scan image index is {col,row}; the table is laid out by {row,col}.
    function automatic logic [3:0] key_lut(input logic [3:0] idx);
        logic [3:0] rc;
        rc = {idx[1:0], idx[3:2]};
        case (rc)
            4'b00_00: key_lut = 4'h1;
            4'b00_01: key_lut = 4'h2;
            4'b00_10: key_lut = 4'h3;
            4'b00_11: key_lut = 4'hA;
            4'b01_00: key_lut = 4'h4;
            4'b01_01: key_lut = 4'h5;
            4'b01_10: key_lut = 4'h6;
            4'b01_11: key_lut = 4'hB;
            4'b10_00: key_lut = 4'h7;
            4'b10_01: key_lut = 4'h8;
            4'b10_10: key_lut = 4'h9;
            4'b10_11: key_lut = 4'hC;
            4'b11_00: key_lut = 4'h0;
            4'b11_01: key_lut = 4'hF;
            4'b11_10: key_lut = 4'hE;
            4'b11_11: key_lut = 4'hD;
            default:  key_lut = 4'h0;
        endcase
    endfunction

    // Classify the completed scan image by counting pressed (low) bits.
    always_comb begin
        zcnt = '0;
        zidx = '0;
        for (int i = 0; i < 16; i++) begin
            if (!acc_q[i]) begin
                zcnt = zcnt + 5'd1;
                zidx = 4'(i);
            end
        end
        if (zcnt == 5'd0)      cls = C_NONE;
        else if (zcnt == 5'd1) cls = C_SINGLE;
        else                   cls = C_MULTI;
        code = key_lut(zidx);
        same = prev_vld_q && (cls == prev_cls_q) &&
               ((cls != C_SINGLE) || (code == prev_code_q));
    end

    // Next-state: column scan, sampling, debounce and output decisions.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        col_n_d     = col_n_q;
        dwell_d     = dwell_q;
        row_s1_d    = row_n;
        row_s2_d    = row_s1_q;
        acc_d       = acc_q;
        prev_vld_d  = prev_vld_q;
        prev_cls_d  = prev_cls_q;
        prev_code_d = prev_code_q;
        match_d     = match_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        multi_key_d = multi_key_q;
        case (state_q)
            S_DRIVE: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    acc_d[{col_q, 2'b00} +: 4] = row_s2_q;
                    if (col_q == 2'd3) begin
                        state_d = S_EVAL;
                    end else begin
                        col_d   = col_q + 2'd1;
                        col_n_d = ~(4'b0001 << (col_q + 2'd1));
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            S_EVAL: begin
                state_d     = S_DRIVE;
                col_d       = 2'd0;
                col_n_d     = 4'b1110;
                dwell_d     = '0;
                prev_vld_d  = 1'b1;
                prev_cls_d  = cls;
                prev_code_d = code;
                if (same) match_d = (match_q == MATCH_MAX) ? MATCH_MAX : match_q + MW'(1);
                else      match_d = MW'(1);
                // Act only on the scan where the result first becomes stable.
                if (match_d == MATCH_MAX && match_q != MATCH_MAX) begin
                    case (cls)
                        C_SINGLE: begin
                            if (!(key_held_q && key_code_q == code)) begin
                                key_code_d  = code;
                                key_held_d  = 1'b1;
                                multi_key_d = 1'b0;
                                key_valid_d = 1'b1;
                            end
                        end
                        C_MULTI: begin
                            multi_key_d = 1'b1;
                            key_held_d  = 1'b0;
                        end
                        default: begin
                            multi_key_d = 1'b0;
                            key_held_d  = 1'b0;
                        end
                    endcase
                end
            end
            default: state_d = S_DRIVE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_DRIVE;
            col_q       <= 2'd0;
            col_n_q     <= 4'b1110;
            dwell_q     <= '0;
            row_s1_q    <= 4'hF;
            row_s2_q    <= 4'hF;
            acc_q       <= 16'hFFFF;
            prev_vld_q  <= 1'b0;
            prev_cls_q  <= C_NONE;
            prev_code_q <= 4'h0;
            match_q     <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            multi_key_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            col_n_q     <= col_n_d;
            dwell_q     <= dwell_d;
            row_s1_q    <= row_s1_d;
            row_s2_q    <= row_s2_d;
            acc_q       <= acc_d;
            prev_vld_q  <= prev_vld_d;
            prev_cls_q  <= prev_cls_d;
            prev_code_q <= prev_code_d;
            match_q     <= match_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            multi_key_q <= multi_key_d;
        end
    end

    assign col_n     = col_n_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign multi_key = multi_key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulates the keypad matrix, keeps a scan-level
// reference model and checks DUT outputs from a separate monitor.
module tb_keypad_scanner;

    localparam int DWELL = 8;
    localparam int SCAN  = 4 * DWELL + 1;
    localparam int STAB  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] col_n, row_n, key_code;
    logic       key_valid, key_held, multi_key;

    bit [15:0]  keys = '0;          // pressed keys, index row*4+col
    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'h0, 4'hF, 4'hE, 4'hD};

    int total = 0;
    int bad   = 0;
    int pulse_cnt = 0;
    bit mon_en = 1'b0;

    // reference model state
    int         ph;
    int         prev_res;
    int         mcnt;
    bit [15:0]  samp;
    logic [3:0] exp_code;
    logic       exp_held, exp_multi, exp_valid;
    int         exp_col;
    logic [3:0] pq[$];

    always #5 clk = ~clk;

    keypad_scanner #(.CLK_FREQ(4_000_000), .COL_DWELL_US(2), .STABLE_SCANS(STAB)) dut (
        .clk(clk), .rst(rst), .col_n(col_n), .row_n(row_n),
        .key_code(key_code), .key_valid(key_valid),
        .key_held(key_held), .multi_key(multi_key)
    );

    // keypad matrix: a pressed key on the driven column pulls its row low
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (col_n[c] == 1'b0 && keys[r*4+c]) row_n[r] = 1'b0;
    end

    function automatic bit [15:0] mask_of(input logic [3:0] k);
        bit [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) if (kmap[i] == k) m[i] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each scan sees keys at a fixed phase per column,
    // then a result repeated STAB scans in a row is acted on once.
    always @(posedge clk) begin
        if (!rst) begin
            ph = 0; prev_res = -1; mcnt = 0; samp = '0;
            exp_code = 4'h0; exp_held = 1'b0; exp_multi = 1'b0;
            exp_valid = 1'b0; exp_col = 0;
        end else begin
            int m, c, nk, res, idx, old;
            m = ph % SCAN;
            exp_valid = 1'b0;
            if (m < SCAN - 1 && m % DWELL == DWELL - 3) begin
                c = m / DWELL;
                for (int r = 0; r < 4; r++) samp[r*4+c] = keys[r*4+c];
            end
            if (m == SCAN - 1) begin
                nk = $countones(samp);
                idx = 0;
                for (int i = 0; i < 16; i++) if (samp[i]) idx = i;
                res = (nk == 0) ? 16 : (nk > 1) ? 17 : int'(kmap[idx]);
                old = mcnt;
                if (res == prev_res) mcnt = (mcnt < STAB) ? mcnt + 1 : STAB;
                else mcnt = 1;
                prev_res = res;
                if (mcnt == STAB && old < STAB) begin
                    if (res == 16) begin
                        exp_held = 1'b0; exp_multi = 1'b0;
                    end else if (res == 17) begin
                        exp_held = 1'b0; exp_multi = 1'b1;
                    end else if (!(exp_held && exp_code == 4'(res))) begin
                        exp_code = 4'(res); exp_held = 1'b1; exp_multi = 1'b0;
                        exp_valid = 1'b1;
                        pq.push_back(4'(res));
                    end
                end
            end
            if (m == DWELL - 1 || m == 2*DWELL - 1 || m == 3*DWELL - 1) exp_col++;
            else if (m == SCAN - 1) exp_col = 0;
            ph++;
        end
    end

    // Monitor: compares outputs each cycle; pops the pulse queue on key_valid.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [3:0] one, ec, got;
            one = 4'b0001;
            ec = ~(one << exp_col);
            chk("col_n", col_n, ec);
            chk("key_code", key_code, exp_code);
            chk("key_held", {3'b0, key_held}, {3'b0, exp_held});
            chk("multi_key", {3'b0, multi_key}, {3'b0, exp_multi});
            chk("key_valid", {3'b0, key_valid}, {3'b0, exp_valid});
            if (key_valid === 1'b1) begin
                pulse_cnt++;
                if (pq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL pulse_unexpected: got code %h expected no pulse", key_code);
                end else begin
                    got = pq.pop_front();
                    chk("pulse_code", key_code, got);
                end
            end
        end
    end

    task automatic wait_scans(input int n);
        repeat (n * SCAN) @(negedge clk);
    endtask

    initial begin
        int p0, kind, hold;
        logic [3:0] k1, k2;
        keys = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_col_n", col_n, 4'b1110);
        chk("reset_code", key_code, 4'h0);
        mon_en = 1'b1;
        rst = 1'b1;

        // idle rotation, no key
        wait_scans(6);
        chk("idle_pulses", 4'(pulse_cnt), 4'd0);

        // steady "5"
        p0 = pulse_cnt;
        keys = mask_of(4'h5);
        wait_scans(7);
        chk("k5_code", key_code, 4'h5);
        chk("k5_held", {3'b0, key_held}, 4'd1);
        chk("k5_pulses", 4'(pulse_cnt - p0), 4'd1);
        keys = '0;
        wait_scans(6);

        // bouncing "D" then steady
        p0 = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            keys = keys ^ mask_of(4'hD);
            repeat (20) @(negedge clk);
        end
        wait_scans(7);
        chk("kD_code", key_code, 4'hD);
        chk("kD_pulses", 4'(pulse_cnt - p0), 4'd1);
        keys = '0;
        wait_scans(6);

        // "1" and "A" together, then release "A"
        p0 = pulse_cnt;
        keys = mask_of(4'h1) | mask_of(4'hA);
        wait_scans(6);
        chk("multi_flag", {3'b0, multi_key}, 4'd1);
        chk("multi_held", {3'b0, key_held}, 4'd0);
        chk("multi_code", key_code, 4'hD);
        chk("multi_pulses", 4'(pulse_cnt - p0), 4'd0);
        keys = mask_of(4'h1);
        wait_scans(6);
        chk("k1_code", key_code, 4'h1);
        chk("k1_pulses", 4'(pulse_cnt - p0), 4'd1);

        // "7" then "8" without release
        p0 = pulse_cnt;
        keys = mask_of(4'h7);
        wait_scans(6);
        keys = mask_of(4'h8);
        wait_scans(6);
        chk("k8_code", key_code, 4'h8);
        chk("k78_pulses", 4'(pulse_cnt - p0), 4'd2);
        keys = '0;
        wait_scans(6);
        chk("rel_held", {3'b0, key_held}, 4'd0);
        chk("rel_code", key_code, 4'h8);

        // reset mid-scan while "3" is held
        keys = mask_of(4'h3);
        wait_scans(6);
        repeat ($urandom_range(1, SCAN - 1)) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_col_n", col_n, 4'b1110);
        chk("rst_code", key_code, 4'h0);
        chk("rst_held", {3'b0, key_held}, 4'd0);
        rst = 1'b1;
        p0 = pulse_cnt;
        wait_scans(6);
        chk("k3_code", key_code, 4'h3);
        chk("k3_pulses", 4'(pulse_cnt - p0), 4'd1);
        keys = '0;
        wait_scans(6);

        // randomized presses, bounces and chords
        for (int n = 0; n < 16; n++) begin
            kind = $urandom_range(0, 3);
            k1 = 4'($urandom_range(0, 15));
            k2 = 4'($urandom_range(0, 15));
            hold = $urandom_range(20, 250);
            case (kind)
                0: keys = '0;
                1: keys = mask_of(k1);
                2: keys = mask_of(k1) | mask_of(k2);
                default: begin
                    for (int i = 0; i < 4; i++) begin
                        keys = keys ^ mask_of(k1);
                        repeat ($urandom_range(5, 30)) @(negedge clk);
                    end
                end
            endcase
            repeat (hold) @(negedge clk);
        end
        keys = '0;
        wait_scans(6);
        chk("queue_drained", 4'(pq.size()), 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
